hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls with timeout, branch flushes,
// load-use interlock, operand forwarding select and a saturating stall counter.
module hazard_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       rd_E,
  input  logic             reg_wr_E,
  input  logic             mem_rd_E,
  input  logic [4:0]       rd_M,
  input  logic             reg_wr_M,
  input  logic             mem_rd_M,
  input  logic [4:0]       rd_W,
  input  logic             reg_wr_W,
  input  logic             branch_taken_E,
  input  logic             mem_req_M,
  input  logic             mem_ready,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic [1:0]       fwd_a_E,
  output logic [1:0]       fwd_b_E,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WCNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [WCNT_W-1:0] wcnt_r;
  logic [WCNT_W-1:0] wcnt_nxt_s;
  logic              mem_timeout_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic              mem_wait_s;
  logic              load_use_s;

  // A writer in M only forwards if it is not a load; M takes priority over W.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (reg_wr_M && !mem_rd_M && (rd_M != 5'd0) && (rd_M == rs)) begin
      return 2'b10;
    end else if (reg_wr_W && (rd_W != 5'd0) && (rd_W == rs)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  // Next-state and wait-counter logic for the data-memory handshake.
  always_comb begin
    state_nxt_s = state_r;
    wcnt_nxt_s  = wcnt_r;
    case (state_r)
      RUN: begin
        if (mem_req_M && !mem_ready) begin
          state_nxt_s = MEM_WAIT;
          wcnt_nxt_s  = WCNT_W'(1);
        end else begin
          state_nxt_s = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt_s = RUN;
        end else if (wcnt_r == WCNT_W'(MAX_WAIT)) begin
          state_nxt_s = ERR;
        end else begin
          wcnt_nxt_s = wcnt_r + WCNT_W'(1);
        end
      end
      ERR: begin
        state_nxt_s = ERR;
      end
      default: begin
        state_nxt_s = RUN;
        wcnt_nxt_s  = '0;
      end
    endcase
  end

  assign mem_wait_s = ((state_r == MEM_WAIT) && !mem_ready) ||
                      ((state_r == RUN) && mem_req_M && !mem_ready) ||
                      (state_r == ERR);
  assign load_use_s = mem_rd_E && reg_wr_E && (rd_E != 5'd0) &&
                      ((rd_E == rs1_D) || (rd_E == rs2_D));

  // Stall/flush priority: reset, memory wait, branch, load-use.
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    if (!rst) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else if (mem_wait_s) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      stall_E = 1'b1;
      stall_M = 1'b1;
    end else if (branch_taken_E) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else if (load_use_s) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      flush_E = 1'b1;
    end else begin
      stall_F = 1'b0;
    end
  end

  assign fwd_a_E = rst ? fwd_sel(rs1_E) : 2'b00;
  assign fwd_b_E = rst ? fwd_sel(rs2_E) : 2'b00;

  // State, wait counter, sticky timeout flag and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= RUN;
      wcnt_r        <= '0;
      mem_timeout_r <= 1'b0;
      stall_cnt_r   <= '0;
    end else begin
      state_r       <= state_nxt_s;
      wcnt_r        <= wcnt_nxt_s;
      mem_timeout_r <= (state_nxt_s == ERR);
      if (stall_F && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
    end
  end

  assign mem_timeout = mem_timeout_r;
  assign stall_cnt   = stall_cnt_r;

endmodule
